// File: rtl/md5_ctrl_pkg.sv
// md5_ctrl_pkg
//   Shared definitions for the MD5 brute-force command controller:
//   host opcodes, controller state encodings, argument-target encoding,
//   reset defaults for the target digest and character range, and the
//   character-range argument validity check.
package md5_ctrl_pkg;

    // Host command opcodes
    localparam logic [31:0] OP_NOP        = 32'h0000_0000;
    localparam logic [31:0] OP_RESET_GEN  = 32'h5230_0000;
    localparam logic [31:0] OP_START_GEN  = 32'h5230_0001;
    localparam logic [31:0] OP_SET_A      = 32'h5230_1000;
    localparam logic [31:0] OP_SET_B      = 32'h5230_1001;
    localparam logic [31:0] OP_SET_C      = 32'h5230_1002;
    localparam logic [31:0] OP_SET_D      = 32'h5230_1003;
    localparam logic [31:0] OP_SET_RANGE  = 32'h5230_2000;
    localparam logic [31:0] OP_GET_CNT_LO = 32'h5230_3000;
    localparam logic [31:0] OP_GET_CNT_HI = 32'h5230_3001;
    localparam logic [31:0] OP_GET_STATUS = 32'h5230_4000;

    // Command decoder: IDLE decodes opcodes, ARG consumes one argument word
    typedef enum logic {
        CS_IDLE = 1'b0,
        CS_ARG  = 1'b1
    } cmd_state_t;

    // Run phase; the encoding is reported verbatim in the status word
    typedef enum logic [1:0] {
        RS_HALT     = 2'd0,
        RS_RUN_WARM = 2'd1,
        RS_RUN      = 2'd2,
        RS_DONE     = 2'd3
    } run_state_t;

    // Register written by the argument word that follows a SET_* command
    typedef enum logic [2:0] {
        TGT_A     = 3'd0,
        TGT_B     = 3'd1,
        TGT_C     = 3'd2,
        TGT_D     = 3'd3,
        TGT_RANGE = 3'd4
    } arg_tgt_t;

    // Reset defaults
    localparam logic [31:0] DEF_EXPECTED_A = 32'hFFFF_FFFF;
    localparam logic [31:0] DEF_EXPECTED_B = 32'h0000_0000;
    localparam logic [31:0] DEF_EXPECTED_C = 32'h0000_0000;
    localparam logic [31:0] DEF_EXPECTED_D = 32'h0000_0000;
    localparam logic [7:0]  DEF_RANGE_MIN  = 8'h61;   // 'a'
    localparam logic [7:0]  DEF_RANGE_MAX  = 8'h7A;   // 'z'

    // Printable ASCII limits for the character range
    localparam logic [7:0]  PRINT_LO = 8'h20;
    localparam logic [7:0]  PRINT_HI = 8'h7E;

    // A range argument is usable only if both bytes are printable and min <= max.
    function automatic logic range_arg_ok(input logic [31:0] arg);
        logic [7:0] lo;
        logic [7:0] hi;
        lo = arg[7:0];
        hi = arg[15:8];
        return (lo >= PRINT_LO) && (lo <= PRINT_HI) &&
               (hi >= PRINT_LO) && (hi <= PRINT_HI) &&
               (lo <= hi);
    endfunction

endpackage

// File: rtl/md5_cmd_controller.sv
// md5_cmd_controller
//   Single-clock command controller for the MD5 brute-force engine.
//   Decodes 32-bit host words, holds the target digest and character range,
//   sequences generator reset / run / freeze, gates match reporting until the
//   hash pipeline is full, and answers host reads with a one-word response.
//
// Ports
//   clk          in   system clock (rising edge)
//   reset2       in   asynchronous active-high reset
//   rx_valid     in   one-cycle strobe: rx_data holds a new host word
//   rx_data      in   command or argument word
//   core_match   in   comparator hit from the datapath
//   core_count   in   candidates evaluated since generator release
//   gen_reset    out  holds generator and datapath counters in reset
//   core_run     out  datapath enable
//   expected_a..d out target digest words
//   range_min/max out printable character bounds
//   matched      out  sticky match flag
//   tx_valid     out  one-cycle strobe: tx_data valid
//   tx_data      out  response word
//   cmd_err      out  one-cycle strobe: command rejected
module md5_cmd_controller
    import md5_ctrl_pkg::*;
#(
    parameter int PIPE_DEPTH = 64,
    parameter int WARM_W     = 7
) (
    input  logic        clk,
    input  logic        reset2,
    input  logic        rx_valid,
    input  logic [31:0] rx_data,
    input  logic        core_match,
    input  logic [63:0] core_count,
    output logic        gen_reset,
    output logic        core_run,
    output logic [31:0] expected_a,
    output logic [31:0] expected_b,
    output logic [31:0] expected_c,
    output logic [31:0] expected_d,
    output logic [7:0]  range_min,
    output logic [7:0]  range_max,
    output logic        matched,
    output logic        tx_valid,
    output logic [31:0] tx_data,
    output logic        cmd_err
);

    // Warm-up ends on the cycle the counter reaches this value
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(PIPE_DEPTH - 1);

    cmd_state_t         r_cmd_state;
    run_state_t         r_run_state;
    arg_tgt_t           r_arg_tgt;
    logic [WARM_W-1:0]  r_warm_cnt;
    logic [63:0]        r_snapshot;
    logic               r_gen_reset;
    logic               r_core_run;
    logic               r_matched;
    logic [31:0]        r_expected_a;
    logic [31:0]        r_expected_b;
    logic [31:0]        r_expected_c;
    logic [31:0]        r_expected_d;
    logic [7:0]         r_range_min;
    logic [7:0]         r_range_max;
    logic               r_tx_valid;
    logic [31:0]        r_tx_data;
    logic               r_cmd_err;

    logic               w_halted;
    logic [31:0]        w_status;

    assign w_halted = (r_run_state == RS_HALT);
    assign w_status = {28'h0, r_run_state, r_core_run, r_matched};

    always_ff @(posedge clk or posedge reset2) begin
        if (reset2) begin
            r_cmd_state  <= CS_IDLE;
            r_run_state  <= RS_HALT;
            r_arg_tgt    <= TGT_A;
            r_warm_cnt   <= '0;
            r_snapshot   <= '0;
            r_gen_reset  <= 1'b1;
            r_core_run   <= 1'b0;
            r_matched    <= 1'b0;
            r_expected_a <= DEF_EXPECTED_A;
            r_expected_b <= DEF_EXPECTED_B;
            r_expected_c <= DEF_EXPECTED_C;
            r_expected_d <= DEF_EXPECTED_D;
            r_range_min  <= DEF_RANGE_MIN;
            r_range_max  <= DEF_RANGE_MAX;
            r_tx_valid   <= 1'b0;
            r_tx_data    <= '0;
            r_cmd_err    <= 1'b0;
        end else begin
            r_tx_valid <= 1'b0;
            r_cmd_err  <= 1'b0;

            // Run-phase progression. Host commands below are evaluated
            // afterwards so that RESET_GEN overrides a same-cycle match.
            case (r_run_state)
                RS_RUN_WARM: begin
                    if (r_warm_cnt == WARM_LAST) begin
                        r_run_state <= RS_RUN;
                    end else begin
                        r_warm_cnt <= r_warm_cnt + WARM_W'(1);
                    end
                end
                RS_RUN: begin
                    if (core_match) begin
                        r_matched   <= 1'b1;
                        r_core_run  <= 1'b0;
                        r_run_state <= RS_DONE;
                    end
                end
                default: ;
            endcase

            if (rx_valid) begin
                if (r_cmd_state == CS_ARG) begin
                    // Any word is taken as the argument, even one that looks like an opcode
                    r_cmd_state <= CS_IDLE;
                    case (r_arg_tgt)
                        TGT_A: r_expected_a <= rx_data;
                        TGT_B: r_expected_b <= rx_data;
                        TGT_C: r_expected_c <= rx_data;
                        TGT_D: r_expected_d <= rx_data;
                        TGT_RANGE: begin
                            if (range_arg_ok(rx_data)) begin
                                r_range_min <= rx_data[7:0];
                                r_range_max <= rx_data[15:8];
                            end else begin
                                r_cmd_err <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    case (rx_data)
                        OP_NOP: ;
                        OP_RESET_GEN: begin
                            r_gen_reset <= 1'b1;
                            r_core_run  <= 1'b0;
                            r_matched   <= 1'b0;
                            r_warm_cnt  <= '0;
                            r_run_state <= RS_HALT;
                        end
                        OP_START_GEN: begin
                            if (w_halted) begin
                                r_gen_reset <= 1'b0;
                                r_core_run  <= 1'b1;
                                r_warm_cnt  <= '0;
                                r_run_state <= RS_RUN_WARM;
                            end else begin
                                r_cmd_err <= 1'b1;
                            end
                        end
                        OP_SET_A, OP_SET_B, OP_SET_C, OP_SET_D, OP_SET_RANGE: begin
                            // Rejected SETs leave the decoder in IDLE so the
                            // next word is treated as a fresh command.
                            if (w_halted) begin
                                r_cmd_state <= CS_ARG;
                                case (rx_data)
                                    OP_SET_A: r_arg_tgt <= TGT_A;
                                    OP_SET_B: r_arg_tgt <= TGT_B;
                                    OP_SET_C: r_arg_tgt <= TGT_C;
                                    OP_SET_D: r_arg_tgt <= TGT_D;
                                    default:  r_arg_tgt <= TGT_RANGE;
                                endcase
                            end else begin
                                r_cmd_err <= 1'b1;
                            end
                        end
                        OP_GET_CNT_LO: begin
                            // Capture all 64 bits so a later HI read pairs with this LO
                            r_snapshot <= core_count;
                            r_tx_valid <= 1'b1;
                            r_tx_data  <= core_count[31:0];
                        end
                        OP_GET_CNT_HI: begin
                            r_tx_valid <= 1'b1;
                            r_tx_data  <= r_snapshot[63:32];
                        end
                        OP_GET_STATUS: begin
                            r_tx_valid <= 1'b1;
                            r_tx_data  <= w_status;
                        end
                        default: r_cmd_err <= 1'b1;
                    endcase
                end
            end
        end
    end

    assign gen_reset  = r_gen_reset;
    assign core_run   = r_core_run;
    assign matched    = r_matched;
    assign expected_a = r_expected_a;
    assign expected_b = r_expected_b;
    assign expected_c = r_expected_c;
    assign expected_d = r_expected_d;
    assign range_min  = r_range_min;
    assign range_max  = r_range_max;
    assign tx_valid   = r_tx_valid;
    assign tx_data    = r_tx_data;
    assign cmd_err    = r_cmd_err;

endmodule

// File: tb/tb_md5_cmd_controller.sv
// tb_md5_cmd_controller
//   Self-checking bench for md5_cmd_controller: directed scenarios with literal
//   expectations followed by randomized host traffic, all compared every cycle
//   against a behavioural model.
module tb_md5_cmd_controller;

    localparam int PIPE_DEPTH = 64;

    localparam logic [31:0] C_RESET  = 32'h5230_0000;
    localparam logic [31:0] C_START  = 32'h5230_0001;
    localparam logic [31:0] C_SETA   = 32'h5230_1000;
    localparam logic [31:0] C_SETB   = 32'h5230_1001;
    localparam logic [31:0] C_SETC   = 32'h5230_1002;
    localparam logic [31:0] C_SETRNG = 32'h5230_2000;
    localparam logic [31:0] C_CNTLO  = 32'h5230_3000;
    localparam logic [31:0] C_CNTHI  = 32'h5230_3001;
    localparam logic [31:0] C_STATUS = 32'h5230_4000;
    localparam logic [31:0] C_NOP    = 32'h0000_0000;

    logic        clk;
    logic        reset2;
    logic        rx_valid;
    logic [31:0] rx_data;
    logic        core_match;
    logic [63:0] core_count;
    logic        gen_reset;
    logic        core_run;
    logic [31:0] expected_a;
    logic [31:0] expected_b;
    logic [31:0] expected_c;
    logic [31:0] expected_d;
    logic [7:0]  range_min;
    logic [7:0]  range_max;
    logic        matched;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic        cmd_err;

    md5_cmd_controller #(.PIPE_DEPTH(PIPE_DEPTH), .WARM_W(7)) dut (
        .clk        (clk),
        .reset2     (reset2),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .core_match (core_match),
        .core_count (core_count),
        .gen_reset  (gen_reset),
        .core_run   (core_run),
        .expected_a (expected_a),
        .expected_b (expected_b),
        .expected_c (expected_c),
        .expected_d (expected_d),
        .range_min  (range_min),
        .range_max  (range_max),
        .matched    (matched),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .cmd_err    (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    // phase: generator halted, started (warm-up or running), or done.
    // Warm-up vs running is derived from how many edges have passed since START.
    localparam int PH_HALT = 0;
    localparam int PH_GO   = 1;
    localparam int PH_DONE = 2;

    int          m_phase;
    int          m_cyc;
    int          m_start;
    int          m_pend;          // -1 none, 0..3 digest word, 4 range
    logic [31:0] m_exp [4];
    logic [7:0]  m_rmin, m_rmax;
    logic [63:0] m_snap;
    logic        m_txv, m_err;
    logic [31:0] m_txd;
    int          m_k;
    logic [1:0]  m_rs;
    logic [31:0] m_stat;

    // Run-state code after edge n
    function automatic logic [1:0] run_code(input int n);
        if (m_phase == PH_HALT) return 2'd0;
        if (m_phase == PH_DONE) return 2'd3;
        return ((n - m_start) < PIPE_DEPTH) ? 2'd1 : 2'd2;
    endfunction

    always @(posedge clk or posedge reset2) begin
        if (reset2) begin
            m_phase = PH_HALT; m_cyc = 0; m_start = 0; m_pend = -1;
            m_exp[0] = 32'hFFFF_FFFF; m_exp[1] = 0; m_exp[2] = 0; m_exp[3] = 0;
            m_rmin = 8'h61; m_rmax = 8'h7A; m_snap = 0;
            m_txv = 0; m_err = 0; m_txd = 0;
        end else begin
            m_cyc++;
            m_k = m_cyc;
            m_rs = run_code(m_k - 1);
            m_stat = {28'h0, m_rs, (m_phase == PH_GO), (m_phase == PH_DONE)};
            m_txv = 0;
            m_err = 0;
            if (m_phase == PH_GO && core_match && run_code(m_k - 1) == 2'd2)
                m_phase = PH_DONE;
            if (rx_valid) begin
                if (m_pend >= 0) begin
                    if (m_pend < 4) m_exp[m_pend] = rx_data;
                    else if (rx_data[7:0] >= 8'h20 && rx_data[15:8] <= 8'h7E &&
                             rx_data[7:0] <= rx_data[15:8]) begin
                        m_rmin = rx_data[7:0];
                        m_rmax = rx_data[15:8];
                    end else m_err = 1;
                    m_pend = -1;
                end else if (rx_data == C_NOP) begin
                end else if (rx_data == C_RESET) begin
                    m_phase = PH_HALT;
                end else if (rx_data == C_START) begin
                    if (m_phase == PH_HALT) begin m_phase = PH_GO; m_start = m_k; end
                    else m_err = 1;
                end else if (rx_data >= C_SETA && rx_data <= C_SETA + 3 || rx_data == C_SETRNG) begin
                    if (m_phase == PH_HALT)
                        m_pend = (rx_data == C_SETRNG) ? 4 : int'(rx_data - C_SETA);
                    else m_err = 1;
                end else if (rx_data == C_CNTLO) begin
                    m_snap = core_count; m_txv = 1; m_txd = core_count[31:0];
                end else if (rx_data == C_CNTHI) begin
                    m_txv = 1; m_txd = m_snap[63:32];
                end else if (rx_data == C_STATUS) begin
                    m_txv = 1; m_txd = m_stat;
                end else m_err = 1;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("gen_reset",  gen_reset,  m_phase == PH_HALT);
        chk("core_run",   core_run,   m_phase == PH_GO);
        chk("matched",    matched,    m_phase == PH_DONE);
        chk("tx_valid",   tx_valid,   m_txv);
        chk("tx_data",    tx_data,    m_txd);
        chk("cmd_err",    cmd_err,    m_err);
        chk("expected_a", expected_a, m_exp[0]);
        chk("expected_b", expected_b, m_exp[1]);
        chk("expected_c", expected_c, m_exp[2]);
        chk("expected_d", expected_d, m_exp[3]);
        chk("range_min",  range_min,  m_rmin);
        chk("range_max",  range_max,  m_rmax);
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one word for one edge; returns 1 ns after that edge
    task automatic send(input logic [31:0] w);
        rx_valid = 1'b1;
        rx_data  = w;
        step(1);
        rx_valid = 1'b0;
        rx_data  = $urandom;
    endtask

    function automatic logic [31:0] rand_word();
        int r;
        logic [31:0] w;
        r = $urandom_range(0, 99);
        if      (r < 3)  w = C_RESET;
        else if (r < 10) w = C_START;
        else if (r < 30) begin
            case ($urandom_range(0, 4))
                0: w = C_SETA;
                1: w = C_SETB;
                2: w = C_SETC;
                3: w = C_SETA + 3;
                default: w = C_SETRNG;
            endcase
        end
        else if (r < 40) w = C_CNTLO;
        else if (r < 48) w = C_CNTHI;
        else if (r < 58) w = C_STATUS;
        else if (r < 63) w = C_NOP;
        else if (r < 70) w = $urandom;
        else w = {16'($urandom), 8'($urandom_range(8'h18, 8'h84)), 8'($urandom_range(8'h18, 8'h84))};
        return w;
    endfunction

    initial begin
        reset2     = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = '0;
        core_match = 1'b0;
        core_count = 64'h1234_5678_9ABC_DEF0;
        #1 reset2 = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset2 = 1'b0;

        // Reset state and first read latency
        send(C_STATUS);
        chk("lit_status_valid", tx_valid, 1'b1);
        chk("lit_status_reset", tx_data, 32'h0000_0000);
        chk("lit_range_min_rst", range_min, 8'h61);
        chk("lit_range_max_rst", range_max, 8'h7A);
        chk("lit_exp_a_rst", expected_a, 32'hFFFF_FFFF);
        chk("lit_gen_reset_rst", gen_reset, 1'b1);
        send(C_CNTHI);
        chk("lit_cnthi_noprior", tx_data, 32'h0);

        // Digest and range programming
        send(C_SETB);
        send(32'hDEAD_BEEF);
        chk("lit_exp_b", expected_b, 32'hDEAD_BEEF);
        send(C_SETRNG);
        send(32'h0000_7A7B);
        chk("lit_range_err", cmd_err, 1'b1);
        chk("lit_range_kept", range_min, 8'h61);
        send(C_SETRNG);
        send(32'h0000_7E20);
        chk("lit_range_ok_min", range_min, 8'h20);
        chk("lit_range_ok_max", range_max, 8'h7E);
        chk("lit_range_ok_err", cmd_err, 1'b0);

        // Warm-up gating and match
        send(C_START);
        chk("lit_start_run", core_run, 1'b1);
        chk("lit_start_genrst", gen_reset, 1'b0);
        step(9);
        core_match = 1'b1;
        step(1);
        core_match = 1'b0;
        chk("lit_warm10_ignored", matched, 1'b0);
        step(53);
        core_match = 1'b1;
        step(1);
        core_match = 1'b0;
        chk("lit_warm_last_ignored", matched, 1'b0);
        core_match = 1'b1;
        send(C_STATUS);
        core_match = 1'b0;
        chk("lit_status_run", tx_data, 32'h0000_000A);
        chk("lit_matched", matched, 1'b1);
        chk("lit_frozen", core_run, 1'b0);
        send(C_STATUS);
        chk("lit_status_done", tx_data, 32'h0000_000D);

        // Coherent counter snapshot
        core_count = 64'h0000_0001_FFFF_FFFF;
        send(C_CNTLO);
        chk("lit_cntlo", tx_data, 32'hFFFF_FFFF);
        core_count = 64'h0000_0002_0000_0005;
        send(C_CNTHI);
        chk("lit_cnthi", tx_data, 32'h0000_0001);

        // Rejected SET while running, then RESET_GEN decoded as a command
        send(C_RESET);
        send(C_START);
        step(PIPE_DEPTH);
        send(C_SETA);
        chk("lit_seta_run_err", cmd_err, 1'b1);
        send(32'h5230_0000);
        chk("lit_reset_decoded", gen_reset, 1'b1);
        chk("lit_reset_noerr", cmd_err, 1'b0);
        send(C_START);
        step(PIPE_DEPTH);
        core_match = 1'b1;
        send(C_RESET);
        core_match = 1'b0;
        chk("lit_reset_wins", matched, 1'b0);
        chk("lit_reset_wins_gr", gen_reset, 1'b1);

        // Asynchronous reset between SET_C and its argument
        send(C_SETC);
        send(32'h1111_1111);
        chk("lit_exp_c", expected_c, 32'h1111_1111);
        send(C_SETC);
        reset2 = 1'b1;
        #3 reset2 = 1'b0;
        chk("lit_exp_c_cleared", expected_c, 32'h0);
        step(1);
        send(32'h1234_5678);
        chk("lit_arg_lost_err", cmd_err, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            core_count = {$urandom, $urandom};
            core_match = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 999) < 3) begin
                reset2 = 1'b1;
                step(1);
                reset2 = 1'b0;
            end else if ($urandom_range(0, 9) < 6) begin
                send(rand_word());
            end else begin
                step(1);
            end
        end
        core_match = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/md5_cmd_controller.md
# md5_cmd_controller

Synchronous command controller for the MD5 brute-force engine. It decodes 32-bit command words from the host receiver and holds the target digest and character range. It sequences generator reset, run and freeze, and gates match reporting until the 64-stage hash pipeline holds valid candidates. It answers host reads through a single-word transmit port. It sits between the UART word receiver/transmitter and the chunk generator plus `Md5Core` datapath, and replaces the receive-strobe-clocked control logic with a single-clock design.

## Interface
- PIPE_DEPTH, 64: cycles from generator release to the first valid digest at the comparator.
- WARM_W, 7: width of the warm-up counter; must hold PIPE_DEPTH.
- clk  in  1  system clock; all logic is rising-edge.
- reset2  in  1  asynchronous, active-high reset.
- rx_valid  in  1  one-cycle pulse, synchronous to clk: rx_data holds a new word.
- rx_data  in  32  command or argument word.
- core_match  in  1  comparator hit from datapath (digest == expected, this cycle).
- core_count  in  64  candidates evaluated since generator release.
- gen_reset  out  1  holds chunk generator and datapath counters in reset.
- core_run  out  1  datapath enable; low freezes generator and text pipeline.
- expected_a, expected_b, expected_c, expected_d  out  32 each  target digest words.
- range_min, range_max  out  8 each  printable character bounds.
- matched  out  1  sticky match flag.
- tx_valid  out  1  one-cycle pulse: tx_data valid.
- tx_data  out  32  response word.
- cmd_err  out  1  one-cycle pulse: command rejected.

## Operation
- Opcodes:
  - RESET_GEN 0x52300000
  - START_GEN 0x52300001
  - SET_A..SET_D 0x52301000..0x52301003
  - SET_RANGE 0x52302000
  - GET_CNT_LO 0x52303000
  - GET_CNT_HI 0x52303001
  - GET_STATUS 0x52304000
  - NOP 0x00000000
- States:
  - IDLE: decode rx_data on rx_valid.
  - ARG: the next rx_valid word is the argument for the latched target (A/B/C/D/RANGE). Return to IDLE after it.
  - RUN_WARM, RUN, DONE: run phase, tracked alongside IDLE/ARG decoding via the run_state field.
- RESET_GEN, accepted in any run_state:
  - gen_reset=1, core_run=0, matched=0, warm counter=0.
  - run_state → HALT.
- START_GEN:
  - Accepted only in HALT; otherwise cmd_err.
  - gen_reset=0, core_run=1, run_state → RUN_WARM.
- RUN_WARM: the warm counter increments each cycle. When it equals PIPE_DEPTH-1, run_state → RUN.
- RUN: core_match=1 sets matched=1 and core_run=0, and run_state → DONE.
- DONE: matched and core_run hold until RESET_GEN.
- core_match is ignored in HALT, RUN_WARM and DONE.
- SET_A..SET_D and SET_RANGE:
  - Accepted only in HALT. Otherwise cmd_err; the state stays IDLE, so the following word is decoded as a command.
- SET_RANGE argument:
  - min=arg[7:0], max=arg[15:8].
  - If min>max, or either byte is outside 0x20..0x7E: cmd_err, old range kept.
- GET_CNT_LO:
  - Snapshots all 64 bits of core_count into the snapshot register.
  - Returns snapshot[31:0].
- GET_CNT_HI: returns snapshot[63:32]. The hi/lo pair is coherent; HI without a prior LO returns 0 after reset.
- GET_STATUS returns {28'h0, run_state[1:0], core_run, matched}, with HALT=0, RUN_WARM=1, RUN=2, DONE=3.
- Unknown opcode in IDLE: cmd_err, no state change. NOP: no effect, no cmd_err.

## Timing
- Reset values:
  - gen_reset=1, core_run=0, matched=0, tx_valid=0, tx_data=0, cmd_err=0.
  - expected_a=0xFFFFFFFF, expected_b/c/d=0.
  - range_min=0x61, range_max=0x7A.
  - Command state IDLE, run_state HALT, snapshot=0.
- All outputs are registered. The effect of a word appears on the cycle after its rx_valid cycle.
- tx_valid and cmd_err are asserted for exactly one cycle, one cycle after rx_valid.
- The RUN→DONE transition and matched rise occur one cycle after the core_match cycle. core_run falls on that same cycle.
- If core_match coincides with RUN_WARM's last cycle, it is ignored.
- rx_valid RESET_GEN in the same cycle as core_match: the reset wins, and matched stays 0.
- Back-to-back rx_valid on every cycle must be accepted with no drops.
- reset2 mid-ARG: the argument is lost, and all registers return to their reset values immediately (asynchronous).

## Structure
- Package md5_ctrl_pkg holds:
  - the opcode localparams;
  - the cmd_state_t (IDLE, ARG) and run_state_t (HALT, RUN_WARM, RUN, DONE) enums;
  - the arg-target encoding;
  - the reset-default constants for the digest and range.
- Single module, no sub-module. The warm counter and snapshot register are inline.

## Test plan
- After reset: GET_STATUS → tx_data=0x00000000, one cycle after rx_valid. range_min/max=0x61/0x7A, expected_a=0xFFFFFFFF.
- SET_B, then 0xDEADBEEF, in HALT → expected_b=0xDEADBEEF. SET_RANGE with arg 0x00007A7B (min 0x7B > max 0x7A) → cmd_err pulse, range unchanged.
- START_GEN; core_match pulsed at warm cycle 10 → ignored. After PIPE_DEPTH cycles, core_match → matched=1, core_run=0, GET_STATUS → 0x0000000D.
- core_count=0x00000001_FFFFFFFF; GET_CNT_LO → 0xFFFFFFFF. core_count then changes to 0x00000002_00000005; GET_CNT_HI → 0x00000001.
- While in RUN: SET_A → cmd_err, and the following word 0x52300000 is decoded as RESET_GEN → gen_reset=1. RESET_GEN coincident with core_match → matched stays 0.
- reset2 asserted between SET_C and its argument → expected_c=0, state IDLE. The next word 0x12345678 → cmd_err.
